mbinit_repairval_fsm: RTL and testbench
=======================================

Name: mbinit_repairval_fsm

Overview:
- Requester-side sequencer for the MBINIT.REPAIRVAL substep. It sits directly downstream of the REPAIRCLK stage and is enabled by that stage's done flag.
- It exchanges init, result and done request/response pairs with the partner over the sideband. Between init and result it drives the valid-lane training pattern.
- It checks the logged valid-lane result, then signals completion to the REVERSALMB stage. It raises a training error on a failed result or on a response timeout.

Parameters:
- TIMEOUT_CYCLES, 24'd8_000_000: cycles a waiting state may persist before a timeout error (8 ms at 1 GHz).
- CNT_W, 24: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_MBINIT_REPAIRCLK_end  in  1  REPAIRCLK stage complete; level enable for this block
- i_Rx_SbMessage  in  4  decoded received sideband message
- i_msg_valid  in  1  i_Rx_SbMessage valid this cycle
- i_Busy_SideBand  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse when TX busy deasserts (message sent)
- i_VAL_pattern_done  in  1  pattern generator finished 128 VALTRAINCK iterations
- i_VAL_result_logged  in  1  partner-reported valid-lane result, captured by RX sideband with result_resp; 1 = pass
- o_MBINIT_REPAIRVAL_Pattern_En  out  1  enable valid-lane pattern generator
- o_TX_SbMessage  out  4  sideband message to transmit
- o_ValidOutDatat_Module  out  1  o_TX_SbMessage valid
- o_train_error_req  out  1  request TRAINERROR
- o_MBINIT_REPAIRVAL_Module_end  out  1  REPAIRVAL complete; level signal

Behaviour:
- Message codes are fixed:
  - init_req 4'b0001, init_resp 4'b0010
  - result_req 4'b0011, result_resp 4'b0100
  - done_req 4'b0101, done_resp 4'b0110
- All outputs are registered and decoded from NS. Every output resets to 0. Outputs reflect the new state one cycle after the transition condition.
- Global abort: i_MBINIT_REPAIRCLK_end = 0 forces NS = IDLE from any state. The timeout counter clears; outputs return to 0 on the next edge.
- States and transitions:
  - IDLE -> INIT_REQ when enable = 1 and ~busy.
  - INIT_REQ (valid = 1, msg = init_req) -> WAIT_RESP on i_falling_edge_busy. Register exp_resp = init_resp.
  - WAIT_RESP -> next state on i_msg_valid with i_Rx_SbMessage == exp_resp:
    - init_resp -> VALPATTERN
    - result_resp -> CHECK_RESULT
    - done_resp -> DONE
  - WAIT_RESP ignores a valid message whose code differs from exp_resp. It stays in the state and the counter keeps running.
  - VALPATTERN (Pattern_En = 1) -> CHECK_BUSY_RESULT on i_VAL_pattern_done.
  - CHECK_BUSY_RESULT -> RESULT_REQ when ~busy.
  - RESULT_REQ (valid = 1, msg = result_req) -> WAIT_RESP on falling_edge_busy && ~busy. Register exp_resp = result_resp.
  - CHECK_RESULT:
    - i_VAL_result_logged = 1 -> CHECK_BUSY_DONE.
    - Otherwise -> ERROR.
  - CHECK_BUSY_DONE -> DONE_REQ when ~busy.
  - DONE_REQ (valid = 1, msg = done_req) -> WAIT_RESP on falling_edge_busy && ~busy. Register exp_resp = done_resp.
  - DONE (Module_end = 1, held) stays until the enable drops.
  - ERROR (train_error_req = 1, held) stays until the enable drops.
  - Undefined encodings -> IDLE.
- Timeout:
  - Counter runs in INIT_REQ, WAIT_RESP, VALPATTERN, RESULT_REQ and DONE_REQ.
  - Counter clears on any state change and in all other states.
  - Counter == TIMEOUT_CYCLES-1 -> NS = ERROR. Timeout takes priority over a same-cycle advance condition.
  - The counter saturates and never wraps.
- Simultaneous events:
  - Enable drop beats timeout, which beats a normal advance.
  - A pattern_done arriving in any state other than VALPATTERN is ignored.
- Reset mid-operation: every state, output and counter returns to 0 immediately and asynchronously.

Decomposition:
- Shared package mbinit_pkg holds:
  - the sideband message codes, shared with the other MBINIT substeps;
  - the state encoding enum;
  - the default for TIMEOUT_CYCLES.
- One natural sub-module, mbinit_timeout_cnt: a saturating counter with clear and run inputs and an expired output. It is reusable by the other MBINIT substeps.

Test Plan:
- Happy path:
  - Stimulus: enable = 1; busy pulses after each request; matching responses returned; pattern_done after 20 cycles; result = 1.
  - Response: o_TX_SbMessage sequence 1, 3, 5, each with valid = 1; Pattern_En high until 1 cycle after pattern_done; Module_end = 1 and held; train_error_req never 1.
- Fail result:
  - Stimulus: as happy path but i_VAL_result_logged = 0 at result_resp.
  - Response: train_error_req = 1 one cycle after CHECK_RESULT, held; done_req never sent.
- Wrong response:
  - Stimulus: in WAIT_RESP after init_req, inject a valid done_resp (4'b0110), then init_resp 5 cycles later.
  - Response: the first message is ignored; Pattern_En asserts only after init_resp.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 50; no init_resp is ever sent.
  - Response: train_error_req = 1 exactly 50 cycles after entry to INIT_REQ; no other outputs active.
- Abort:
  - Stimulus: drop enable during VALPATTERN.
  - Response: Pattern_En = 0 on the next edge; FSM in IDLE; re-enabling restarts with init_req.
- Async reset:
  - Stimulus: assert rst_n = 0 mid-RESULT_REQ, with no clock edge.
  - Response: all outputs 0 immediately; after release the block waits for enable and ~busy.

Source files
------------

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes,
// REPAIRVAL state encoding and timeout default.
package mbinit_pkg;

  localparam logic [3:0] MSG_INIT_REQ    = 4'b0001;
  localparam logic [3:0] MSG_INIT_RESP   = 4'b0010;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'b0011;
  localparam logic [3:0] MSG_RESULT_RESP = 4'b0100;
  localparam logic [3:0] MSG_DONE_REQ    = 4'b0101;
  localparam logic [3:0] MSG_DONE_RESP   = 4'b0110;

  localparam logic [23:0] TIMEOUT_DEF = 24'd8_000_000;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_INIT_REQ      = 4'd1,
    ST_WAIT_RESP     = 4'd2,
    ST_VALPATTERN    = 4'd3,
    ST_CHK_BUSY_RES  = 4'd4,
    ST_RESULT_REQ    = 4'd5,
    ST_CHK_RESULT    = 4'd6,
    ST_CHK_BUSY_DONE = 4'd7,
    ST_DONE_REQ      = 4'd8,
    ST_DONE          = 4'd9,
    ST_ERROR         = 4'd10
  } state_t;

  // States in which the partner or pattern gen must make progress
  function automatic logic timed(input state_t s);
    return (s == ST_INIT_REQ)   ||
           (s == ST_WAIT_RESP)  ||
           (s == ST_VALPATTERN) ||
           (s == ST_RESULT_REQ) ||
           (s == ST_DONE_REQ);
  endfunction

endpackage

// File: rtl/mbinit_repairval_fsm_if.sv
// REPAIRVAL sideband/pattern bundle.
// master: the FSM side; slave: sideband/pattern/neighbour side.
interface mbinit_repairval_fsm_if;
  import mbinit_pkg::*;

  logic       i_MBINIT_REPAIRCLK_end;
  logic [3:0] i_Rx_SbMessage;
  logic       i_msg_valid;
  logic       i_Busy_SideBand;
  logic       i_falling_edge_busy;
  logic       i_VAL_pattern_done;
  logic       i_VAL_result_logged;
  logic       o_MBINIT_REPAIRVAL_Pattern_En;
  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutDatat_Module;
  logic       o_train_error_req;
  logic       o_MBINIT_REPAIRVAL_Module_end;

  modport master (
    input  i_MBINIT_REPAIRCLK_end,
    input  i_Rx_SbMessage,
    input  i_msg_valid,
    input  i_Busy_SideBand,
    input  i_falling_edge_busy,
    input  i_VAL_pattern_done,
    input  i_VAL_result_logged,
    output o_MBINIT_REPAIRVAL_Pattern_En,
    output o_TX_SbMessage,
    output o_ValidOutDatat_Module,
    output o_train_error_req,
    output o_MBINIT_REPAIRVAL_Module_end
  );

  modport slave (
    output i_MBINIT_REPAIRCLK_end,
    output i_Rx_SbMessage,
    output i_msg_valid,
    output i_Busy_SideBand,
    output i_falling_edge_busy,
    output i_VAL_pattern_done,
    output i_VAL_result_logged,
    input  o_MBINIT_REPAIRVAL_Pattern_En,
    input  o_TX_SbMessage,
    input  o_ValidOutDatat_Module,
    input  o_train_error_req,
    input  o_MBINIT_REPAIRVAL_Module_end
  );

endinterface

// File: rtl/mbinit_timeout_cnt.sv
// Saturating wait-time counter for MBINIT substeps.
// Ports: CLK, rst_n, clr, run in; expired out at LIMIT-1.
module mbinit_timeout_cnt #(
  parameter int                CNT_W = 24,
  parameter logic [CNT_W-1:0]  LIMIT = '1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = LIMIT - 1'b1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mbinit_repairval_fsm.sv
// MBINIT.REPAIRVAL requester sequencer: init/result/done
// exchange, valid-lane pattern, result check, timeout.
// Ports: CLK, rst_n, bus (mbinit_repairval_fsm_if.master).
module mbinit_repairval_fsm
  import mbinit_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int          CNT_W          = 24
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  mbinit_repairval_fsm_if.master        bus
);

  state_t     st, ns;
  logic [3:0] exp_q, exp_nx;
  logic       expired, to_hit;
  logic       en, busy, fe;

  logic       pat_en_q, valid_q, err_q, end_q;
  logic [3:0] msg_q;

  assign en   = bus.i_MBINIT_REPAIRCLK_end;
  assign busy = bus.i_Busy_SideBand;
  assign fe   = bus.i_falling_edge_busy;

  mbinit_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (CNT_W'(TIMEOUT_CYCLES))
  ) u_to (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .clr     ((ns != st) || !timed(st)),
    .run     (timed(st)),
    .expired (expired)
  );

  // Counter is held at zero outside timed states
  assign to_hit = expired && timed(st);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      exp_q <= '0;
    end else begin
      st    <= ns;
      exp_q <= exp_nx;
    end
  end

  always_comb begin
    ns     = st;
    exp_nx = exp_q;
    if (!en) begin
      ns = ST_IDLE;
    end else if (to_hit) begin
      ns = ST_ERROR;
    end else begin
      case (st)
        ST_IDLE:
          if (!busy) ns = ST_INIT_REQ;
        ST_INIT_REQ:
          if (fe) begin
            ns     = ST_WAIT_RESP;
            exp_nx = MSG_INIT_RESP;
          end
        ST_WAIT_RESP:
          if (bus.i_msg_valid &&
              (bus.i_Rx_SbMessage == exp_q)) begin
            case (exp_q)
              MSG_INIT_RESP:   ns = ST_VALPATTERN;
              MSG_RESULT_RESP: ns = ST_CHK_RESULT;
              MSG_DONE_RESP:   ns = ST_DONE;
              default:         ns = ST_WAIT_RESP;
            endcase
          end
        ST_VALPATTERN:
          if (bus.i_VAL_pattern_done) ns = ST_CHK_BUSY_RES;
        ST_CHK_BUSY_RES:
          if (!busy) ns = ST_RESULT_REQ;
        ST_RESULT_REQ:
          if (fe && !busy) begin
            ns     = ST_WAIT_RESP;
            exp_nx = MSG_RESULT_RESP;
          end
        ST_CHK_RESULT:
          ns = bus.i_VAL_result_logged ? ST_CHK_BUSY_DONE
                                       : ST_ERROR;
        ST_CHK_BUSY_DONE:
          if (!busy) ns = ST_DONE_REQ;
        ST_DONE_REQ:
          if (fe && !busy) begin
            ns     = ST_WAIT_RESP;
            exp_nx = MSG_DONE_RESP;
          end
        ST_DONE:  ns = ST_DONE;
        ST_ERROR: ns = ST_ERROR;
        default:  ns = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state and registered
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pat_en_q <= 1'b0;
      valid_q  <= 1'b0;
      msg_q    <= '0;
      err_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      pat_en_q <= (ns == ST_VALPATTERN);
      err_q    <= (ns == ST_ERROR);
      end_q    <= (ns == ST_DONE);
      valid_q  <= (ns == ST_INIT_REQ)   ||
                  (ns == ST_RESULT_REQ) ||
                  (ns == ST_DONE_REQ);
      case (ns)
        ST_INIT_REQ:   msg_q <= MSG_INIT_REQ;
        ST_RESULT_REQ: msg_q <= MSG_RESULT_REQ;
        ST_DONE_REQ:   msg_q <= MSG_DONE_REQ;
        default:       msg_q <= '0;
      endcase
    end
  end

  assign bus.o_MBINIT_REPAIRVAL_Pattern_En = pat_en_q;
  assign bus.o_TX_SbMessage                = msg_q;
  assign bus.o_ValidOutDatat_Module        = valid_q;
  assign bus.o_train_error_req             = err_q;
  assign bus.o_MBINIT_REPAIRVAL_Module_end = end_q;

endmodule

// File: tb/tb_mbinit_repairval_fsm.sv
// Bench for mbinit_repairval_fsm: TX message scoreboard
// plus direct output checks across the REPAIRVAL flow.
module tb_mbinit_repairval_fsm;
  import mbinit_pkg::*;

  logic CLK = 1'b0;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;
  logic [3:0] exp_q[$];
  logic v_prev = 1'b0;
  logic err_seen = 1'b0;

  mbinit_repairval_fsm_if bus ();

  mbinit_repairval_fsm #(
    .TIMEOUT_CYCLES (24'd50),
    .CNT_W          (24)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // TX monitor: each new request is checked against the queue
  always @(negedge CLK) begin
    if (bus.o_ValidOutDatat_Module && !v_prev) begin
      if (exp_q.size() == 0)
        chk("tx_unexp", 32'(bus.o_TX_SbMessage), 32'd0);
      else
        chk("tx_msg", 32'(bus.o_TX_SbMessage),
            32'(exp_q.pop_front()));
    end
    if (bus.o_train_error_req) err_seen <= 1'b1;
    v_prev <= bus.o_ValidOutDatat_Module;
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.o_ValidOutDatat_Module && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk(tag, 32'd0, 32'd1);
  endtask

  // Sideband TX model: busy for two cycles, then sent
  task automatic sb_send(input string tag);
    wait_valid(tag);
    bus.i_Busy_SideBand = 1'b1;
    tick();
    tick();
    bus.i_Busy_SideBand     = 1'b0;
    bus.i_falling_edge_busy = 1'b1;
    tick();
    bus.i_falling_edge_busy = 1'b0;
  endtask

  task automatic resp(input logic [3:0] c);
    bus.i_Rx_SbMessage = c;
    bus.i_msg_valid    = 1'b1;
    tick();
    bus.i_msg_valid    = 1'b0;
    bus.i_Rx_SbMessage = '0;
  endtask

  task automatic start_init();
    exp_q.push_back(MSG_INIT_REQ);
    bus.i_MBINIT_REPAIRCLK_end = 1'b1;
    sb_send("to_init");
  endtask

  task automatic pat_done();
    exp_q.push_back(MSG_RESULT_REQ);
    bus.i_VAL_pattern_done = 1'b1;
    tick();
    bus.i_VAL_pattern_done = 1'b0;
    chk("pat_off", 32'(bus.o_MBINIT_REPAIRVAL_Pattern_En), 0);
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {27'd0,
              bus.o_MBINIT_REPAIRVAL_Pattern_En,
              bus.o_ValidOutDatat_Module,
              bus.o_train_error_req,
              bus.o_MBINIT_REPAIRVAL_Module_end,
              |bus.o_TX_SbMessage}, 32'd0);
  endtask

  task automatic disable_en();
    bus.i_MBINIT_REPAIRCLK_end = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.i_MBINIT_REPAIRCLK_end = 1'b0;
    bus.i_Rx_SbMessage         = '0;
    bus.i_msg_valid            = 1'b0;
    bus.i_Busy_SideBand        = 1'b0;
    bus.i_falling_edge_busy    = 1'b0;
    bus.i_VAL_pattern_done     = 1'b0;
    bus.i_VAL_result_logged    = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    all_zero("reset_outs");
    rst_n = 1'b1;
    tick();
    all_zero("idle_no_en");

    // Happy path
    err_seen = 1'b0;
    start_init();
    resp(MSG_INIT_RESP);
    chk("pat_on", 32'(bus.o_MBINIT_REPAIRVAL_Pattern_En), 1);
    repeat (19) tick();
    chk("pat_hold", 32'(bus.o_MBINIT_REPAIRVAL_Pattern_En), 1);
    pat_done();
    sb_send("to_result");
    bus.i_VAL_result_logged = 1'b1;
    exp_q.push_back(MSG_DONE_REQ);
    resp(MSG_RESULT_RESP);
    sb_send("to_donereq");
    resp(MSG_DONE_RESP);
    chk("end_on", 32'(bus.o_MBINIT_REPAIRVAL_Module_end), 1);
    repeat (3) tick();
    chk("end_hold", 32'(bus.o_MBINIT_REPAIRVAL_Module_end), 1);
    chk("happy_no_err", 32'(err_seen), 0);
    disable_en();
    chk("end_drop", 32'(bus.o_MBINIT_REPAIRVAL_Module_end), 0);

    // Failing result
    bus.i_VAL_result_logged = 1'b0;
    start_init();
    resp(MSG_INIT_RESP);
    repeat (5) tick();
    pat_done();
    sb_send("to_result_f");
    resp(MSG_RESULT_RESP);
    chk("err_pre", 32'(bus.o_train_error_req), 0);
    tick();
    chk("err_on", 32'(bus.o_train_error_req), 1);
    repeat (4) tick();
    chk("err_hold", 32'(bus.o_train_error_req), 1);
    chk("err_no_tx", 32'(bus.o_ValidOutDatat_Module), 0);
    disable_en();
    all_zero("err_drop");

    // Wrong response ignored, then abort in VALPATTERN
    start_init();
    resp(MSG_DONE_RESP);
    repeat (4) tick();
    chk("wrong_ign", 32'(bus.o_MBINIT_REPAIRVAL_Pattern_En), 0);
    resp(MSG_INIT_RESP);
    chk("right_resp", 32'(bus.o_MBINIT_REPAIRVAL_Pattern_En), 1);
    bus.i_MBINIT_REPAIRCLK_end = 1'b0;
    tick();
    all_zero("abort");

    // Restart and time out in INIT_REQ (no busy, no resp)
    exp_q.push_back(MSG_INIT_REQ);
    bus.i_MBINIT_REPAIRCLK_end = 1'b1;
    repeat (50) tick();
    chk("to_pre_err", 32'(bus.o_train_error_req), 0);
    chk("to_pre_vld", 32'(bus.o_ValidOutDatat_Module), 1);
    tick();
    chk("to_err", 32'(bus.o_train_error_req), 1);
    chk("to_vld_off", 32'(bus.o_ValidOutDatat_Module), 0);
    chk("to_pat_off", 32'(bus.o_MBINIT_REPAIRVAL_Pattern_En), 0);
    disable_en();

    // Async reset in RESULT_REQ
    start_init();
    resp(MSG_INIT_RESP);
    tick();
    pat_done();
    wait_valid("to_result_r");
    chk("rr_msg", 32'(bus.o_TX_SbMessage), 32'(MSG_RESULT_REQ));
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    bus.i_Busy_SideBand = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    all_zero("rst_busy_wait");
    exp_q.push_back(MSG_INIT_REQ);
    bus.i_Busy_SideBand = 1'b0;
    tick();
    chk("rst_restart", 32'(bus.o_ValidOutDatat_Module), 1);
    disable_en();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
